// File: rtl/sher_memory.sv
// Unified instruction/data memory for the Sher-VI processor: five asynchronous
// read ports and one synchronous write port with an optional companion-word clear.
module sher_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] sr1,
  input  logic [DATA_WIDTH-1:0] sr2,
  input  logic [DATA_WIDTH-1:0] sr3,
  input  logic [DATA_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] two,
  input  logic                  MEMWRITE,
  input  logic                  WRITEZERO,
  output logic [DATA_WIDTH-1:0] IRO,
  output logic [DATA_WIDTH-1:0] IRT,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3
);

  localparam int IW = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [DATA_WIDTH-1:0] pc_two_s;
  logic [DATA_WIDTH-1:0] rd_two_s;

  // Byte address to word index: drop bit 0, wrap modulo MEM_WORDS.
  function automatic logic [IW-1:0] word_idx(input logic [DATA_WIDTH-1:0] addr);
    return IW'(addr >> 1);
  endfunction

  assign pc_two_s = pc + two;
  assign rd_two_s = rd + two;

  assign IRO  = mem[word_idx(pc)];
  assign IRT  = mem[word_idx(pc_two_s)];
  assign out1 = mem[word_idx(sr1)];
  assign out2 = mem[word_idx(sr2)];
  assign out3 = mem[word_idx(sr3)];

  // Storage update: reset clears all words; companion clear is issued before the
  // data write so that on an index collision the data write takes effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (MEMWRITE) begin
      if (WRITEZERO) begin
        mem[word_idx(rd_two_s)] <= '0;
      end
      mem[word_idx(rd)] <= data;
    end
  end

endmodule

// File: tb/tb_sher_memory.sv
// Self-checking bench for sher_memory: directed test-plan steps followed by
// randomized traffic compared against an array-based reference model.
module tb_sher_memory;

  localparam int DW = 16;
  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data, sr1, sr2, sr3, rd, pc, two;
  logic          MEMWRITE, WRITEZERO;
  logic [DW-1:0] IRO, IRT, out1, out2, out3;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model [MW];

  sher_memory #(.DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .data(data),
    .sr1(sr1), .sr2(sr2), .sr3(sr3), .rd(rd), .pc(pc), .two(two),
    .MEMWRITE(MEMWRITE), .WRITEZERO(WRITEZERO),
    .IRO(IRO), .IRT(IRT), .out1(out1), .out2(out2), .out3(out3)
  );

  always #5 clk = ~clk;

  // Byte address -> word index as plain arithmetic.
  function automatic int idx(input logic [DW-1:0] a);
    return (int'(a) / 2) % MW;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] pt;
    pt = pc + two;
    check({tag, ".IRO"},  IRO,  model[idx(pc)]);
    check({tag, ".IRT"},  IRT,  model[idx(pt)]);
    check({tag, ".out1"}, out1, model[idx(sr1)]);
    check({tag, ".out2"}, out2, model[idx(sr2)]);
    check({tag, ".out3"}, out3, model[idx(sr3)]);
  endtask

  // Apply the current inputs to the model, then let the DUT see one rising edge.
  task automatic edge_step();
    logic [DW-1:0] rt;
    rt = rd + two;
    if (!rst_n) begin
      for (int i = 0; i < MW; i++) model[i] = '0;
    end else if (MEMWRITE) begin
      if (WRITEZERO) model[idx(rt)] = '0;
      model[idx(rd)] = data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [DW-1:0] a, input logic [DW-1:0] d);
    rd = a; data = d; MEMWRITE = 1'b1; WRITEZERO = 1'b0;
    edge_step();
    MEMWRITE = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data = '0; sr1 = '0; sr2 = '0; sr3 = '0; rd = '0; pc = '0;
    two = 16'd2; MEMWRITE = 1'b0; WRITEZERO = 1'b0;
    edge_step();
    rst_n = 1'b1;

    // Preload, then reset with a write pending: reset must win.
    write(16'd0, 16'h1111); write(16'd2, 16'h2222); write(16'd4, 16'h3333);
    write(16'd6, 16'h4444);
    rst_n = 1'b0; rd = 16'd2; data = 16'hBEEF; MEMWRITE = 1'b1; WRITEZERO = 1'b1;
    edge_step();
    rst_n = 1'b1; MEMWRITE = 1'b0; WRITEZERO = 1'b0;
    pc = 16'd0; sr1 = 16'd2; sr2 = 16'd4; sr3 = 16'd6; #1;
    check("reset.IRO", IRO, 16'd0);   check("reset.IRT", IRT, 16'd0);
    check("reset.out1", out1, 16'd0); check("reset.out2", out2, 16'd0);
    check("reset.out3", out3, 16'd0);

    // Fetch
    write(16'd0, 16'd5); write(16'd2, 16'd10);
    pc = 16'd0; two = 16'd2; #1;
    check("fetch.IRO", IRO, 16'd5); check("fetch.IRT", IRT, 16'd10);

    // Operand reads
    write(16'd4, 16'd13); write(16'd6, 16'd27);
    sr1 = 16'd2; sr2 = 16'd4; sr3 = 16'd6; #1;
    check("ops.out1", out1, 16'd10); check("ops.out2", out2, 16'd13);
    check("ops.out3", out3, 16'd27);

    // Branch write with companion clear
    data = 16'd56; rd = 16'd0; two = 16'd2; MEMWRITE = 1'b1; WRITEZERO = 1'b1;
    edge_step();
    MEMWRITE = 1'b0; WRITEZERO = 1'b0;
    sr1 = 16'd0; sr2 = 16'd2; sr3 = 16'd4; #1;
    check("branch.out1", out1, 16'd56); check("branch.out2", out2, 16'd0);
    check("branch.out3", out3, 16'd13);

    // WRITEZERO without MEMWRITE does nothing
    data = 16'hDEAD; rd = 16'd4; MEMWRITE = 1'b0; WRITEZERO = 1'b1;
    edge_step();
    WRITEZERO = 1'b0; sr1 = 16'd4; sr2 = 16'd6; #1;
    check("qual.out1", out1, 16'd13); check("qual.out2", out2, 16'd27);

    // Read-during-write: old value before the edge, new one after
    @(negedge clk);
    sr1 = 16'd8; rd = 16'd8; data = 16'h0077; MEMWRITE = 1'b1; #1;
    check("rdw.before", out1, 16'd0);
    edge_step();
    MEMWRITE = 1'b0;
    check("rdw.after", out1, 16'h0077);

    // Odd address alias, high-bit wrap, two=0 collision
    write(16'd1, 16'd99);
    sr1 = 16'd0; #1; check("alias.odd", out1, 16'd99);
    write(16'd512, 16'h0ABC);
    #1; check("alias.wrap", out1, 16'h0ABC);
    data = 16'h00C5; rd = 16'd10; two = 16'd0; MEMWRITE = 1'b1; WRITEZERO = 1'b1;
    edge_step();
    MEMWRITE = 1'b0; WRITEZERO = 1'b0; sr1 = 16'd10; #1;
    check("collide", out1, 16'h00C5);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(99) != 0);
      data      = DW'($urandom);
      rd        = DW'($urandom);
      MEMWRITE  = ($urandom_range(3) != 0);
      WRITEZERO = $urandom_range(1) == 1;
      case ($urandom_range(3))
        0: two = 16'd0;
        1: two = DW'($urandom);
        default: two = 16'd2;
      endcase
      // Reads are biased towards recently written words to exercise aliasing.
      pc  = $urandom_range(1) ? rd : DW'($urandom);
      sr1 = $urandom_range(1) ? rd : DW'($urandom);
      sr2 = rd + two;
      sr3 = DW'($urandom_range(15));
      #1; check_all("rnd.pre");
      edge_step();
      check_all("rnd.post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
